// File: rtl/alu_packet_pkg.sv
// alu_packet_pkg: parser states, opcode constants and header geometry for alu_packet_ctrl
package alu_packet_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_OPERAND, S_RESULT, S_DRAIN, S_ERR
  } state_e;
  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD   = 8'hA0;
  localparam logic [7:0] OP_MUL   = 8'hB0;
  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam int HDR_BYTES = 4;
endpackage

// File: rtl/alu_packet_outreg.sv
// alu_packet_outreg: single-entry AXI-stream output register (load_i/data_i in, tvalid_o/tdata_o/tready_i stream out, free_o when a load may be taken)
module alu_packet_outreg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         tready_i,
  output logic         tvalid_o,
  output logic [W-1:0] tdata_o,
  output logic         free_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (tready_i) begin
      valid_q <= 1'b0;
    end
  assign free_o   = !valid_q || tready_i;
  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
endmodule

// File: rtl/alu_packet_ctrl.sv
// alu_packet_ctrl: request-stream packet engine (ECHO/ADD32/MUL32) with s_axis request in, m_axis response out, busy_o and packet_count_o
module alu_packet_ctrl
  import alu_packet_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic [15:0]           packet_count_o
);
  state_e                state_q, state_d;
  logic [7:0]            op_q, op_d, len_lo_q, len_lo_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, len, pay;
  logic [31:0]           acc_q, acc_d, opnd_q, opnd_d;
  logic [1:0]            bcnt_q, bcnt_d, idx_q, idx_d;
  logic                  have_q, have_d;
  logic [15:0]           pkt_q;
  logic                  pkt_inc, load, out_free, s_xfer, is_arith;
  logic [DATA_WIDTH-1:0] load_data;
  assign len      = LEN_WIDTH'({s_axis_tdata, len_lo_q});
  assign pay      = len < LEN_WIDTH'(HDR_BYTES) ? '0 : len - LEN_WIDTH'(HDR_BYTES);
  assign is_arith = op_q == OP_ADD || op_q == OP_MUL;
  assign s_xfer   = s_axis_tvalid && s_axis_tready;
  always_comb
    unique case (state_q)
      S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: s_axis_tready = rst_ni;
      S_ECHO:  s_axis_tready = rst_ni && out_free;
      default: s_axis_tready = 1'b0;
    endcase
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_lo_d  = len_lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    bcnt_d    = bcnt_q;
    have_d    = have_q;
    idx_d     = idx_q;
    pkt_inc   = 1'b0;
    load      = 1'b0;
    load_data = s_axis_tdata;
    unique case (state_q)
      S_IDLE: if (s_xfer) begin
        op_d    = s_axis_tdata;
        state_d = S_RSVD;
      end
      S_RSVD: if (s_xfer) state_d = S_LEN_LO;
      S_LEN_LO: if (s_xfer) begin
        len_lo_d = s_axis_tdata;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (s_xfer) begin
        cnt_d  = pay;
        acc_d  = '0;
        opnd_d = '0;
        bcnt_d = '0;
        idx_d  = '0;
        have_d = 1'b0;
        if (op_q == OP_ECHO) begin
          state_d = pay == '0 ? S_IDLE : S_ECHO;
          pkt_inc = pay == '0;
        end else if (is_arith) state_d = pay == '0 ? S_RESULT : S_OPERAND;
        else state_d = pay == '0 ? S_ERR : S_DRAIN;
      end
      S_ECHO: if (s_xfer) begin
        load    = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == LEN_WIDTH'(1) ? S_IDLE : S_ECHO;
        pkt_inc = cnt_q == LEN_WIDTH'(1);
      end
      S_OPERAND: if (s_xfer) begin
        // Operand arrives LSB first, so each byte enters at the top and shifts down.
        opnd_d = {s_axis_tdata, opnd_q[31:8]};
        bcnt_d = bcnt_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (bcnt_q == 2'd3) begin
          acc_d  = !have_q ? opnd_d : op_q == OP_ADD ? acc_q + opnd_d : acc_q * opnd_d;
          have_d = 1'b1;
        end
        state_d = cnt_q == LEN_WIDTH'(1) ? S_RESULT : S_OPERAND;
      end
      S_RESULT: if (out_free) begin
        load      = 1'b1;
        load_data = acc_q[8*idx_q +: 8];
        idx_d     = idx_q + 1'b1;
        state_d   = idx_q == 2'd3 ? S_IDLE : S_RESULT;
        pkt_inc   = idx_q == 2'd3;
      end
      S_DRAIN: if (s_xfer) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == LEN_WIDTH'(1) ? S_ERR : S_DRAIN;
      end
      S_ERR: if (out_free) begin
        load      = 1'b1;
        load_data = ERR_BYTE;
        state_d   = S_IDLE;
        pkt_inc   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      bcnt_q   <= '0;
      idx_q    <= '0;
      have_q   <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      bcnt_q   <= bcnt_d;
      idx_q    <= idx_d;
      have_q   <= have_d;
      pkt_q    <= pkt_q + {15'd0, pkt_inc};
    end
  alu_packet_outreg #(.W(DATA_WIDTH)) u_outreg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .data_i  (load_data),
    .tready_i(m_axis_tready),
    .tvalid_o(m_axis_tvalid),
    .tdata_o (m_axis_tdata),
    .free_o  (out_free)
  );
  assign busy_o         = state_q != S_IDLE || m_axis_tvalid;
  assign packet_count_o = pkt_q;
endmodule

// File: tb/tb_alu_packet_ctrl.sv
// tb_alu_packet_ctrl: directed self-checking bench for alu_packet_ctrl
module tb_alu_packet_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        busy;
  logic [15:0] pkt_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx[$];
  logic [7:0]  ex[$];
  logic [7:0]  mq[$];
  always #5 clk = ~clk;
  alu_packet_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .busy_o        (busy),
    .packet_count_o(pkt_cnt)
  );
  always @(posedge clk)
    if (rst_n && m_tvalid && m_tready) mq.push_back(m_tdata);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_tdata  = b;
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", {31'd0, s_tready}, 32'd1);
    @(posedge clk);
  endtask
  task automatic send_all();
    foreach (tx[i]) send_byte(tx[i]);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask
  task automatic expect_out(input string tag);
    foreach (ex[i]) begin
      int n = 0;
      while (mq.size() == 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (mq.size() == 0) check({tag, "_timeout"}, 32'(mq.size()), 32'd1);
      else check(tag, {24'd0, mq.pop_front()}, {24'd0, ex[i]});
    end
    repeat (3) @(negedge clk);
    check({tag, "_extra"}, 32'(mq.size()), 32'd0);
  endtask
  initial begin
    #2;
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_s_tready", {31'd0, s_tready}, 32'd1);
    tx = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    send_all();
    ex = '{8'h11, 8'h22, 8'h33};
    expect_out("echo");
    check("echo_pkt", {16'd0, pkt_cnt}, 32'd1);
    tx = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_all();
    ex = '{8'h03, 8'h00, 8'h00, 8'h00};
    expect_out("add");
    check("add_pkt", {16'd0, pkt_cnt}, 32'd2);
    tx = '{8'hB0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_all();
    ex = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
    expect_out("mul");
    check("mul_pkt", {16'd0, pkt_cnt}, 32'd3);
    tx = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_all();
    ex = '{8'hEE};
    expect_out("inval");
    check("inval_pkt", {16'd0, pkt_cnt}, 32'd4);
    tx = '{8'hA0, 8'h00, 8'h02, 8'h00};
    send_all();
    ex = '{8'h00, 8'h00, 8'h00, 8'h00};
    expect_out("empty");
    check("empty_pkt", {16'd0, pkt_cnt}, 32'd5);
    tx = '{8'hEC, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02};
    foreach (tx[i]) send_byte(tx[i]);
    @(negedge clk);
    m_tready = 1'b0;
    s_tdata  = 8'h03;
    s_tvalid = 1'b1;
    #1;
    check("bp_s_tready_low", {31'd0, s_tready}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("bp_hold_data", {24'd0, m_tdata}, 32'h02);
      check("bp_hold_valid", {31'd0, m_tvalid}, 32'd1);
      check("bp_s_tready", {31'd0, s_tready}, 32'd0);
    end
    m_tready = 1'b1;
    #1;
    check("bp_resume", {31'd0, s_tready}, 32'd1);
    @(posedge clk);
    send_byte(8'h04);
    send_byte(8'h05);
    @(negedge clk);
    s_tvalid = 1'b0;
    ex = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_out("bp");
    check("bp_pkt", {16'd0, pkt_cnt}, 32'd6);
    tx = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
    foreach (tx[i]) send_byte(tx[i]);
    @(negedge clk);
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mrst_s_tready", {31'd0, s_tready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_pkt", {16'd0, pkt_cnt}, 32'd0);
    repeat (5) @(negedge clk);
    check("mrst_no_out", 32'(mq.size()), 32'd0);
    tx = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_all();
    ex = '{8'h0C, 8'h00, 8'h00, 8'h00};
    expect_out("post_rst_add");
    check("post_rst_pkt", {16'd0, pkt_cnt}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
